// File: rtl/console_register_bank.sv
// QBUS console register bank: CSR, debounced switch register and NREGS display registers
// at consecutive I/O-page word addresses, with byte writes and a vectored change interrupt.
module console_register_bank #(
  parameter int          NREGS           = 4,
  parameter int          DEBOUNCE_CYCLES = 20000,
  parameter logic [15:0] DISP_RESET      = 16'o000000,
  parameter logic [8:0]  VECTOR          = 9'o300
) (
  input  logic                  qclk,
  input  logic                  reset,
  input  logic [21:0]           RAL,
  input  logic                  RBS7,
  input  logic [15:0]           RDL,
  input  logic                  WTBT,
  output logic [15:0]           TDL,
  input  logic [17:0]           addr,
  output logic                  addr_match,
  input  logic                  assert_vector,
  input  logic                  write_pulse,
  input  logic [15:0]           switches,
  output logic [16*NREGS-1:0]   lights,
  output logic                  irq
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [11:0]   off;
  logic          wr;
  logic          wr_lo;
  logic          wr_hi;
  logic          csr_wr;
  logic [15:0]   disp [NREGS];
  logic [15:0]   sync_meta;
  logic [15:0]   sync;
  logic [15:0]   prev;
  logic [15:0]   deb;
  logic [CW-1:0] cnt;
  logic          load;
  logic          chg_set;
  logic          primed;
  logic          chg;
  logic          ie;
  logic          chg_nx;
  logic          ie_nx;
  logic          irq_set;
  logic          irq_clr;
  logic          unused_bits;

  assign unused_bits = ^{RAL[21:13], addr[17:13], addr[0]};

  assign off        = RAL[12:1] - addr[12:1];
  assign addr_match = RBS7 && (off < 12'(NREGS + 2));
  assign wr         = addr_match && write_pulse;
  assign wr_lo      = wr && (!WTBT || !RAL[0]);
  assign wr_hi      = wr && (!WTBT || RAL[0]);
  assign csr_wr     = wr_lo && (off == 12'd0);

  always_ff @(posedge qclk) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) disp[k] <= DISP_RESET;
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        if (wr_lo && off == 12'(k + 2)) disp[k][7:0]  <= RDL[7:0];
        if (wr_hi && off == 12'(k + 2)) disp[k][15:8] <= RDL[15:8];
      end
    end
  end

  always_comb begin
    lights = '0;
    for (int k = 0; k < NREGS; k++) lights[16*k +: 16] = disp[k];
  end

  // A value is accepted once sync has matched prev for DEBOUNCE_CYCLES consecutive cycles.
  assign load    = (sync != deb) && (sync == prev) && (cnt == CNT_LAST);
  assign chg_set = load && primed;

  always_ff @(posedge qclk) begin
    if (reset) begin
      sync_meta <= '0;
      sync      <= '0;
      prev      <= '0;
      deb       <= '0;
      cnt       <= '0;
      primed    <= 1'b0;
    end else begin
      sync_meta <= switches;
      sync      <= sync_meta;
      prev      <= sync;
      if (sync == deb || sync != prev) cnt <= '0;
      else if (cnt == CNT_LAST)        cnt <= '0;
      else                             cnt <= cnt + CW'(1);
      if (load) begin
        deb    <= sync;
        primed <= 1'b1;
      end
    end
  end

  assign ie_nx  = csr_wr ? RDL[6] : ie;
  assign chg_nx = chg_set ? 1'b1 : (csr_wr ? 1'b0 : chg);

  // Writing IE=1 clears CHG, yet the pending change must still raise the request,
  // so the rising test uses CHG as it was before the write.
  assign irq_set = ie_nx && (chg || chg_set) && !(ie && chg);
  assign irq_clr = assert_vector || (csr_wr && !RDL[6]);

  always_ff @(posedge qclk) begin
    if (reset) begin
      chg <= 1'b0;
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      chg <= chg_nx;
      ie  <= ie_nx;
      if (irq_clr)      irq <= 1'b0;
      else if (irq_set) irq <= 1'b1;
    end
  end

  always_comb begin
    TDL = '0;
    if (assert_vector) begin
      TDL = {7'b0, VECTOR};
    end else if (addr_match) begin
      if (off == 12'd0)      TDL = {8'b0, chg, ie, 6'b0};
      else if (off == 12'd1) TDL = deb;
      else begin
        for (int k = 0; k < NREGS; k++)
          if (off == 12'(k + 2)) TDL = disp[k];
      end
    end
  end

endmodule

// File: tb/tb_console_register_bank.sv
// Bench for console_register_bank: vector table, directed debounce/interrupt sequences
// and randomized bus/switch traffic against a behavioural model.
module tb_console_register_bank;
  localparam int          NREGS = 4;
  localparam int          DEB   = 8;
  localparam logic [15:0] DRST  = 16'o052525;
  localparam logic [8:0]  VEC   = 9'o300;

  logic                qclk = 1'b0;
  logic                reset;
  logic [21:0]         RAL;
  logic                RBS7;
  logic [15:0]         RDL;
  logic                WTBT;
  logic [15:0]         TDL;
  logic [17:0]         addr;
  logic                addr_match;
  logic                assert_vector;
  logic                write_pulse;
  logic [15:0]         switches;
  logic [16*NREGS-1:0] lights;
  logic                irq;

  int checks = 0;
  int errors = 0;

  // behavioural model
  logic [15:0] m_disp [NREGS];
  logic [15:0] m_deb, m_s1, m_s2, m_last;
  int          m_run;
  logic        m_ie, m_chg, m_irq, m_primed;

  console_register_bank #(
    .NREGS(NREGS), .DEBOUNCE_CYCLES(DEB), .DISP_RESET(DRST), .VECTOR(VEC)
  ) dut (
    .qclk(qclk), .reset(reset), .RAL(RAL), .RBS7(RBS7), .RDL(RDL), .WTBT(WTBT),
    .TDL(TDL), .addr(addr), .addr_match(addr_match), .assert_vector(assert_vector),
    .write_pulse(write_pulse), .switches(switches), .lights(lights), .irq(irq)
  );

  always #25 qclk = ~qclk;

  typedef struct {
    logic [21:0] ral;
    logic        wtbt;
    logic        wp;
    logic [15:0] rdl;
    logic [15:0] exp_tdl;
    logic        exp_match;
  } vec_t;

  vec_t vecs [13];

  function automatic int model_off(input logic [21:0] ral);
    return (int'(ral >> 1) - int'(addr >> 1)) & 4095;
  endfunction

  function automatic logic [16*NREGS-1:0] model_lights();
    logic [16*NREGS-1:0] v;
    v = '0;
    for (int k = 0; k < NREGS; k++) v[16*k +: 16] = m_disp[k];
    return v;
  endfunction

  function automatic logic [15:0] model_tdl();
    int o;
    o = model_off(RAL);
    if (assert_vector) return {7'b0, VEC};
    if (!RBS7 || o >= NREGS + 2) return 16'h0;
    if (o == 0) return {8'b0, m_chg, m_ie, 6'b0};
    if (o == 1) return m_deb;
    return m_disp[o-2];
  endfunction

  task automatic model_edge();
    logic [15:0] sy;
    int run_n, o;
    bit ld, setc, wr, lo, hi, csr_wr, ie_n, chg_n, was, trig, clr;
    if (reset) begin
      for (int k = 0; k < NREGS; k++) m_disp[k] = DRST;
      m_deb = 0; m_s1 = 0; m_s2 = 0; m_last = 0; m_run = 1;
      m_ie = 0; m_chg = 0; m_irq = 0; m_primed = 0;
      return;
    end
    sy    = m_s2;
    run_n = (sy == m_last) ? m_run + 1 : 1;
    ld    = (sy != m_deb) && (run_n >= DEB + 1);
    setc  = ld && m_primed;
    o     = model_off(RAL);
    wr    = write_pulse && RBS7 && (o < NREGS + 2);
    lo    = wr && (!WTBT || !RAL[0]);
    hi    = wr && (!WTBT ||  RAL[0]);
    if (o >= 2 && o < NREGS + 2) begin
      if (lo) m_disp[o-2][7:0]  = RDL[7:0];
      if (hi) m_disp[o-2][15:8] = RDL[15:8];
    end
    csr_wr = lo && (o == 0);
    ie_n   = csr_wr ? RDL[6] : m_ie;
    chg_n  = setc ? 1'b1 : (csr_wr ? 1'b0 : m_chg);
    was    = m_ie && m_chg;
    trig   = ie_n && (m_chg || setc) && !was;
    clr    = assert_vector || (csr_wr && !RDL[6]);
    if (clr)       m_irq = 0;
    else if (trig) m_irq = 1;
    m_ie = ie_n; m_chg = chg_n;
    if (ld) begin m_deb = sy; m_primed = 1; end
    m_s2 = m_s1; m_s1 = switches; m_last = sy; m_run = run_n;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge qclk);
    #1;
    check("model_lights", 64'(lights), 64'(model_lights()));
    check("model_irq", 64'(irq), 64'(m_irq));
    check("model_addr_match", 64'(addr_match), 64'(RBS7 && model_off(RAL) < NREGS + 2));
    if (RBS7 || assert_vector) check("model_tdl", 64'(TDL), 64'(model_tdl()));
  endtask

  task automatic bus_write(input logic [21:0] ral, input logic [15:0] rdl, input logic wtbt);
    RAL = ral; RDL = rdl; WTBT = wtbt; write_pulse = 1;
    tick();
    write_pulse = 0; WTBT = 0;
  endtask

  task automatic read_check(input string name, input logic [21:0] ral, input logic [15:0] exp);
    RAL = ral; RBS7 = 1;
    #1;
    check(name, 64'(TDL), 64'(exp));
  endtask

  task automatic wait_swr(input string name, input logic [15:0] val, input int exp_cycles);
    int n;
    n = 0;
    RAL = 22'o777562;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (TDL == val) break;
    end
    check(name, 64'(n), 64'(exp_cycles));
  endtask

  initial begin
    vecs[0]  = '{22'o777566, 1'b0, 1'b1, 16'o123456, 16'o123456, 1'b1};
    vecs[1]  = '{22'o777600, 1'b0, 1'b0, 16'o000000, 16'o000000, 1'b0};
    vecs[2]  = '{22'o777564, 1'b0, 1'b1, 16'o177777, 16'o177777, 1'b1};
    vecs[3]  = '{22'o777564, 1'b1, 1'b1, 16'o000012, 16'o177412, 1'b1};
    vecs[4]  = '{22'o777565, 1'b1, 1'b1, 16'h34FF,   16'o032012, 1'b1};
    vecs[5]  = '{22'o777562, 1'b0, 1'b1, 16'o177777, 16'o000000, 1'b1};
    vecs[6]  = '{22'o777560, 1'b0, 1'b1, 16'o000100, 16'o000100, 1'b1};
    vecs[7]  = '{22'o777561, 1'b1, 1'b1, 16'o000000, 16'o000100, 1'b1};
    vecs[8]  = '{22'o777572, 1'b0, 1'b1, 16'o000777, 16'o000777, 1'b1};
    vecs[9]  = '{22'o777570, 1'b0, 1'b0, 16'o000000, 16'o052525, 1'b1};
    vecs[10] = '{22'o777574, 1'b0, 1'b0, 16'o000000, 16'o000000, 1'b0};
    vecs[11] = '{22'o777560, 1'b0, 1'b1, 16'o000000, 16'o000000, 1'b1};
    vecs[12] = '{22'o777556, 1'b0, 1'b0, 16'o000000, 16'o000000, 1'b0};

    reset = 1; RAL = 22'o777560; RBS7 = 1; RDL = 0; WTBT = 0; addr = 18'o777560;
    assert_vector = 0; write_pulse = 0; switches = 0;
    #1;
    tick(); tick();
    reset = 0;

    check("reset_lights", 64'(lights), {4{DRST}});
    check("reset_irq", 64'(irq), 64'(0));
    read_check("reset_csr", 22'o777560, 16'o000000);
    read_check("reset_swr", 22'o777562, 16'o000000);

    for (int i = 0; i < 13; i++) begin
      RAL = vecs[i].ral; WTBT = vecs[i].wtbt; RDL = vecs[i].rdl; write_pulse = vecs[i].wp;
      tick();
      write_pulse = 0; WTBT = 0;
      #1;
      check($sformatf("vec%0d_tdl", i), 64'(TDL), 64'(vecs[i].exp_tdl));
      check($sformatf("vec%0d_match", i), 64'(addr_match), 64'(vecs[i].exp_match));
    end
    check("disp1_lights", 64'(lights[31:16]), 64'(16'o123456));

    // first debounced change after reset only primes the change flag
    switches = 16'o000017;
    wait_swr("first_load_latency", 16'o000017, 11);
    read_check("first_load_no_chg", 22'o777560, 16'o000000);
    switches = 16'o000000;
    wait_swr("second_load_latency", 16'o000000, 11);
    read_check("second_load_chg", 22'o777560, 16'o000200);

    RAL = 22'o777562;
    switches = 16'o000005;
    repeat (5) tick();
    switches = 16'o000000;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("glitch_swr", 64'(TDL), 64'(0));
    end

    // interrupt request and acknowledge
    bus_write(22'o777560, 16'o000100, 1'b0);
    check("ie_write_irq", 64'(irq), 64'(1));
    read_check("ie_write_csr", 22'o777560, 16'o000100);
    assert_vector = 1;
    #1;
    check("vector_tdl", 64'(TDL), 64'(16'o000300));
    tick();
    assert_vector = 0;
    check("ack_irq_clear", 64'(irq), 64'(0));

    switches = 16'o000003;
    RAL = 22'o777562;
    repeat (11) tick();
    check("chg_rise_irq", 64'(irq), 64'(1));
    read_check("chg_rise_csr", 22'o777560, 16'o000300);
    assert_vector = 1;
    tick();
    assert_vector = 0;
    check("ack2_irq_clear", 64'(irq), 64'(0));
    read_check("ack_keeps_chg", 22'o777560, 16'o000300);
    bus_write(22'o777560, 16'o000100, 1'b0);
    read_check("csr_write_clears_chg", 22'o777560, 16'o000100);
    check("rewrite_ie_no_irq", 64'(irq), 64'(0));

    switches = 16'o000000;
    repeat (11) tick();
    check("chg_rise2_irq", 64'(irq), 64'(1));
    bus_write(22'o777560, 16'o000000, 1'b0);
    check("ie_clear_irq", 64'(irq), 64'(0));
    read_check("ie_clear_csr", 22'o777560, 16'o000000);

    // CSR write in the same cycle as a debounced load: set wins
    switches = 16'o000007;
    RAL = 22'o777562;
    repeat (10) tick();
    bus_write(22'o777560, 16'o000100, 1'b0);
    read_check("simul_chg_set_wins", 22'o777560, 16'o000300);
    check("simul_irq", 64'(irq), 64'(1));

    // reset in the middle of a debounce count
    switches = 16'o000070;
    RAL = 22'o777562;
    repeat (6) tick();
    reset = 1;
    bus_write(22'o777566, 16'o111111, 1'b0);
    reset = 0;
    check("midreset_lights", 64'(lights), {4{DRST}});
    check("midreset_irq", 64'(irq), 64'(0));
    read_check("midreset_csr", 22'o777560, 16'o000000);
    read_check("midreset_swr", 22'o777562, 16'o000000);
    wait_swr("post_reset_load_latency", 16'o000070, 11);
    read_check("post_reset_primed", 22'o777560, 16'o000000);

    // randomized traffic against the model
    begin
      int hold;
      hold = 0;
      for (int i = 0; i < 900; i++) begin
        reset         = ($urandom_range(0, 299) == 0);
        RBS7          = ($urandom_range(0, 9) != 0);
        RAL           = 22'o777556 + 22'($urandom_range(0, 20));
        WTBT          = 1'($urandom_range(0, 1));
        RDL           = 16'($urandom);
        write_pulse   = ($urandom_range(0, 2) == 0);
        assert_vector = ($urandom_range(0, 15) == 0);
        if (hold == 0) begin
          switches = 16'($urandom_range(0, 3)) * 16'o001001;
          hold     = $urandom_range(1, 16);
        end
        hold--;
        tick();
      end
      reset = 0; write_pulse = 0; assert_vector = 0; WTBT = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
